// File: rtl/voice_mix_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// voice_mix_scheduler_pkg
// Shared constants and FSM state type for the voice mix scheduler.
//   NUM_VOICES : number of mux slots scanned per pass
//   SEL_W      : width of the external mux select
//   DATA_W     : sample width (unsigned offset-binary)
//   ACC_W      : accumulator width, holds NUM_VOICES * max sample
//   MIX_SHIFT  : fixed right shift applied to the sum (divide by 8)
// -----------------------------------------------------------------------------
package voice_mix_scheduler_pkg;

  localparam int NUM_VOICES = 8;
  localparam int SEL_W      = 3;
  localparam int DATA_W     = 8;
  localparam int ACC_W      = DATA_W + 3;
  localparam int MIX_SHIFT  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/voice_mix_scheduler.sv
// -----------------------------------------------------------------------------
// voice_mix_scheduler
// On each sample_tick, steps the external 8:1 sample mux through all voice
// slots (one per clock), sums the enabled voices and emits the sum / 8 as one
// mixed sample with a single-cycle valid strobe.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   sample_tick  in   one-cycle pulse that starts a mix pass
//   voice_en     in   per-slot enable, latched at the tick
//   mux_data     in   external mux output (combinational from mux_sel)
//   overrun_clr  in   synchronous clear of the overrun flag
//   mux_sel      out  select driven to the external mux
//   mix_out      out  mixed sample, held between passes
//   mix_valid    out  one-cycle pulse when mix_out updates
//   busy         out  high while a pass is in progress (SCAN or DONE)
//   overrun      out  sticky: a tick arrived while busy
// -----------------------------------------------------------------------------
module voice_mix_scheduler
  import voice_mix_scheduler_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  input  logic [NUM_VOICES-1:0] voice_en,
  input  logic [DATA_W-1:0]     mux_data,
  input  logic                  overrun_clr,
  output logic [SEL_W-1:0]      mux_sel,
  output logic [DATA_W-1:0]     mix_out,
  output logic                  mix_valid,
  output logic                  busy,
  output logic                  overrun
);

  state_t                r_state;
  state_t                w_next_state;
  logic [SEL_W-1:0]      r_idx;
  logic [ACC_W-1:0]      r_acc;
  logic [NUM_VOICES-1:0] r_en_q;
  logic [DATA_W-1:0]     r_mix_out;
  logic                  r_overrun;
  logic                  w_last_slot;

  assign w_last_slot = (r_idx == SEL_W'(NUM_VOICES - 1));

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  // NOTE: the default assignment first means every path assigns
  // w_next_state, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (sample_tick) w_next_state = SCAN;
      SCAN:    if (w_last_slot) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: enable latch, slot index, accumulator and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_acc     <= '0;
      r_en_q    <= '0;
      r_mix_out <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (sample_tick) begin
            // Enables are frozen for the whole pass.
            r_en_q <= voice_en;
            r_acc  <= '0;
            r_idx  <= '0;
          end
        end
        SCAN: begin
          // mux_data is combinational from mux_sel, so it belongs to r_idx.
          if (r_en_q[r_idx]) begin
            r_acc <= r_acc + ACC_W'(mux_data);
          end
          if (!w_last_slot) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          // Fixed divide by 8 regardless of how many voices were enabled.
          r_mix_out <= r_acc[ACC_W-1:MIX_SHIFT];
        end
        default: ;
      endcase
    end
  end

  // Sticky overrun: a new event takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (sample_tick && (r_state != IDLE)) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign mux_sel   = (r_state == SCAN) ? r_idx : '0;
  assign busy      = (r_state != IDLE);
  assign mix_valid = (r_state == DONE);
  assign mix_out   = r_mix_out;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_voice_mix_scheduler.sv
// -----------------------------------------------------------------------------
// tb_voice_mix_scheduler
// Self-checking bench: the scheduler drives an 8:1 mux over the voice sample
// array; table-driven passes plus hand-written overrun, back-to-back, enable
// latching and mid-pass reset sequences.
// -----------------------------------------------------------------------------
module tb_voice_mix_scheduler;

  logic            clk;
  logic            rst_n;
  logic            sample_tick;
  logic [7:0]      voice_en;
  logic [7:0]      mux_data;
  logic            overrun_clr;
  logic [2:0]      mux_sel;
  logic [7:0]      mix_out;
  logic            mix_valid;
  logic            busy;
  logic            overrun;

  logic [7:0][7:0] voices;

  int errors = 0;
  int checks = 0;

  // The external 8:1 sample mux.
  assign mux_data = voices[mux_sel];

  voice_mix_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .voice_en    (voice_en),
    .mux_data    (mux_data),
    .overrun_clr (overrun_clr),
    .mux_sel     (mux_sel),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0][7:0] voices;
    logic [7:0]      en;
    logic [7:0]      exp_mix;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0][7:0] fill(input logic [7:0] v);
    logic [7:0][7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v;
    return r;
  endfunction

  // One complete pass: tick in cycle T, observe T+1..T+12.
  task automatic run_pass(input logic [7:0] exp_mix);
    int   lat;
    int   busy_cnt;
    int   valid_cnt;
    logic sel_ok;
    logic [2:0] exp_sel;
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    lat = 0; busy_cnt = 0; valid_cnt = 0; sel_ok = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (mix_valid) begin
        valid_cnt++;
        lat = c;
      end
      exp_sel = (c <= 8) ? 3'(c - 1) : 3'd0;
      if (mux_sel !== exp_sel) sel_ok = 1'b0;
    end
    check("latency", lat, 9);
    check("busy_cycles", busy_cnt, 9);
    check("valid_pulses", valid_cnt, 1);
    check("mux_sel_walk", {31'd0, sel_ok}, 1);
    check("mix_out", {24'd0, mix_out}, {24'd0, exp_mix});
  endtask

  initial begin
    int valid_cnt;

    // Vector table: samples, enables, hand-computed sum >> 3.
    vecs[0] = '{voices: fill(8'h80), en: 8'hFF, exp_mix: 8'h80}; // 1024/8
    vecs[1] = '{voices: fill(8'hFF), en: 8'h08, exp_mix: 8'h1F}; // 255/8
    vecs[2] = '{voices: fill(8'hFF), en: 8'hFF, exp_mix: 8'hFF}; // 2040/8
    vecs[3] = '{voices: fill(8'hFF), en: 8'h00, exp_mix: 8'h00}; // empty pass
    for (int i = 0; i < 8; i++) begin
      vecs[4].voices[i] = 8'((i + 1) * 16);  // 0x10..0x80
      vecs[5].voices[i] = 8'(i + 1);         // 1..8
    end
    vecs[4].en = 8'hAA; vecs[4].exp_mix = 8'h28;  // 32+64+96+128=320 -> 40
    vecs[5].en = 8'hFF; vecs[5].exp_mix = 8'h04;  // 36 -> 4 (truncated)

    rst_n = 1'b0; sample_tick = 1'b0; overrun_clr = 1'b0;
    voice_en = 8'h00; voices = fill(8'h00);
    repeat (3) @(negedge clk);
    check("reset_mux_sel", {29'd0, mux_sel}, 0);
    check("reset_mix_out", {24'd0, mix_out}, 0);
    check("reset_mix_valid", {31'd0, mix_valid}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_overrun", {31'd0, overrun}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      voices   = vecs[v].voices;
      voice_en = vecs[v].en;
      run_pass(vecs[v].exp_mix);
    end

    // Overrun: tick at T+4 ignored, clear, then set-wins with a same-cycle clear.
    voices = fill(8'h80); voice_en = 8'hFF; valid_cnt = 0;
    for (int c = 0; c < 32; c++) begin
      @(posedge clk); #1;
      sample_tick = (c == 0 || c == 4 || c == 20 || c == 23);
      overrun_clr = (c == 12 || c == 23);
      @(negedge clk);
      if (c < 20 && mix_valid) valid_cnt++;
      if (c == 5)  check("ovr_set", {31'd0, overrun}, 1);
      if (c == 9)  check("ovr_valid_t9", {31'd0, mix_valid}, 1);
      if (c == 10) check("ovr_first_result", {24'd0, mix_out}, 8'h80);
      if (c == 11) check("ovr_no_second_pass", {31'd0, busy}, 0);
      if (c == 13) check("ovr_cleared", {31'd0, overrun}, 0);
      if (c == 21) check("ovr_tick_after_clr", {31'd0, busy}, 1);
      if (c == 24) check("ovr_set_wins", {31'd0, overrun}, 1);
    end
    sample_tick = 1'b0; overrun_clr = 1'b0;
    check("ovr_single_valid", valid_cnt, 1);

    // Tick during DONE is an overrun; tick in the next IDLE cycle is accepted.
    @(posedge clk); #1 overrun_clr = 1'b1;
    @(posedge clk); #1 overrun_clr = 1'b0;
    valid_cnt = 0;
    for (int c = 0; c < 22; c++) begin
      @(posedge clk); #1;
      sample_tick = (c == 0 || c == 9 || c == 10);
      @(negedge clk);
      if (mix_valid) valid_cnt++;
      if (c == 10) check("b2b_done_overrun", {31'd0, overrun}, 1);
      if (c == 11) check("b2b_accepted", {31'd0, busy}, 1);
      if (c == 19) check("b2b_second_valid", {31'd0, mix_valid}, 1);
    end
    sample_tick = 1'b0;
    check("b2b_valid_count", valid_cnt, 2);

    // voice_en change mid-pass must not affect the pass.
    voices = fill(8'h40);
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      sample_tick = (c == 0);
      voice_en    = (c >= 3) ? 8'h01 : 8'hFF;
      @(negedge clk);
      if (c == 10) check("en_latched_mix", {24'd0, mix_out}, 8'h40);
    end

    // Asynchronous reset mid-pass (overrun is still set from above).
    voices = fill(8'h80); voice_en = 8'hFF; valid_cnt = 0;
    for (int c = 0; c < 17; c++) begin
      @(posedge clk); #1;
      sample_tick = (c == 0);
      if (c == 5) begin
        rst_n = 1'b0;
        #1;
        check("rst_mid_mux_sel", {29'd0, mux_sel}, 0);
        check("rst_mid_mix_out", {24'd0, mix_out}, 0);
        check("rst_mid_busy", {31'd0, busy}, 0);
        check("rst_mid_valid", {31'd0, mix_valid}, 0);
        check("rst_mid_overrun", {31'd0, overrun}, 0);
      end
      if (c == 7) rst_n = 1'b1;
      @(negedge clk);
      if (mix_valid) valid_cnt++;
    end
    sample_tick = 1'b0;
    check("rst_no_partial_valid", valid_cnt, 0);
    check("rst_no_restart", {31'd0, busy}, 0);
    run_pass(8'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/voice_mix_scheduler.md
Name: voice_mix_scheduler

Overview:
- Sequences the 8-input, 8-bit sample mux: on each audio sample tick it steps the mux select through all 8 voice slots, one slot per clock.
- Accumulates the samples of the enabled voices and emits one mixed 8-bit sample with a valid strobe.
- Sits between the 8 oscillator/voice outputs, which feed the external mux, and the DAC/output stage.

Parameters:
- NUM_VOICES, 8, number of mux slots scanned; fixed at 8 to match the 3-bit select.
- DATA_W, 8, sample width in bits; samples are unsigned offset-binary.
- ACC_W, 11, accumulator width (DATA_W + 3); holds 8 x 255 = 2040 without overflow.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- sample_tick  in  1  one-cycle pulse that starts a mix pass.
- voice_en  in  8  per-slot enable; bit i enables slot i.
- mux_data  in  DATA_W  output of the external mux; combinational from mux_sel, so valid in the same cycle.
- mux_sel  out  3  select driven to the external mux.
- mix_out  out  DATA_W  mixed sample; held between passes.
- mix_valid  out  1  one-cycle pulse when mix_out updates.
- busy  out  1  high while a pass is in progress (SCAN or DONE).
- overrun  out  1  sticky flag: a sample_tick arrived while busy.
- overrun_clr  in  1  synchronous clear of overrun.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - mux_sel=0, mix_out=0, mix_valid=0, busy=0, overrun=0.
  - Accumulator, slot index and latched enable all cleared.
  - Takes effect immediately mid-pass. No partial result is emitted, and scanning restarts only on the next tick after release.
- States are IDLE, SCAN and DONE.
- IDLE:
  - mux_sel=0, busy=0.
  - When sample_tick=1: latch voice_en into en_q, clear acc, set idx=0, go to SCAN.
- SCAN, one cycle per slot:
  - mux_sel=idx.
  - If en_q[idx]=1, acc <= acc + mux_data (zero-extended to ACC_W); otherwise acc is unchanged.
  - If idx==7, go to DONE; otherwise idx <= idx+1.
  - Exactly 8 SCAN cycles; slots are visited in order 0..7 and there is no early exit.
- DONE, one cycle:
  - mix_out <= acc[ACC_W-1:3], i.e. the sum divided by 8 and truncated. This is a fixed divide by 8, not by the number of enabled voices.
  - mix_valid=1 for this cycle only.
  - Go to IDLE.
- Latency: tick sampled in cycle T; SCAN covers T+1..T+8; mix_valid is high in T+9; mix_out is valid from T+10 and holds until the next DONE. Minimum tick spacing is 10 cycles.
- voice_en changes during a pass have no effect on that pass (en_q is latched at the tick).
- voice_en=0x00: the pass still runs; mix_out=0 with mix_valid pulsed.
- sample_tick while busy: ignored, the running pass is unaffected, and overrun is set to 1.
- overrun_clr and a new overrun event in the same cycle: set wins.
- sample_tick in the same cycle as DONE counts as busy and is an overrun. A tick in the first IDLE cycle after DONE is accepted.
- Accumulation never overflows: with ACC_W=11 the maximum is 2040. No saturation logic is required.

Decomposition:
- Shared package contains:
  - the state typedef (IDLE, SCAN, DONE);
  - NUM_VOICES, SEL_W=3, DATA_W and ACC_W constants;
  - MIX_SHIFT=3.
- No sub-module: the 8:1 mux stays an external instance driven by mux_sel, and the integration top wires the two together.
- The bench instantiates the real mux plus this block.

Test Plan:
- All 8 voices at 0x80, voice_en=0xFF, one tick -> mix_out=0x80, mix_valid high exactly 9 cycles after the tick, busy high for 9 cycles.
- Only slot 3 enabled at 0xFF, others at 0xFF but disabled -> acc=255, mix_out=0x1F; mux_sel walks 0..7 during SCAN and returns to 0.
- All voices 0xFF, voice_en=0xFF -> acc=2040, mix_out=0xFF, no wrap. Then voice_en=0x00 -> mix_out=0x00 with mix_valid pulsed.
- Second tick at T+4 -> overrun=1, the first result is unchanged and no second pass starts. overrun_clr -> 0. Tick at T+10 -> accepted.
- Change voice_en from 0xFF to 0x01 at T+3 with all voices at 0x40 -> mix_out=0x40, i.e. the latched enable is used.
- Drop rst_n at T+5 -> all outputs 0 immediately with no mix_valid. Release, tick -> normal result 9 cycles later.
